// File: rtl/hyper_target.sv
// HyperBus target emulator: decodes pin-level CA/latency/data on a fast sampling clock,
// backs reads/writes with a 16-bit RAM plus a small ID/CR0 register space.
module hyper_target #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned LATENCY    = 6,
  parameter bit          DOUBLE_LAT = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       hb_ck,
  input  logic       hb_cs_l,
  input  logic       hb_rst_l,
  input  logic [7:0] dq_in,
  output logic [7:0] dq_out,
  output logic       dq_oe,
  input  logic       rwds_in,
  output logic       rwds_out,
  output logic       rwds_oe,
  output logic       busy
);

  localparam int unsigned TACC    = DOUBLE_LAT ? 2 * LATENCY : LATENCY;
  localparam logic [15:0] D0      = 16'(4 + 2 * TACC);
  localparam logic [15:0] CR0_RST = 16'h8F1F;
  localparam logic [15:0] ID0     = 16'h0C81;

  typedef enum logic [2:0] {S_IDLE, S_CA, S_LAT, S_RDATA, S_WDATA} state_t;

  state_t r_state, w_state_nxt;

  logic              r_ck_s1, r_ck_s2, r_ck_d;
  logic              r_cs_s1, r_cs_s2, r_cs_d;
  logic              r_rst_s1, r_rst_s2;
  logic [7:0]        r_dq_s1, r_dq_s2;
  logic              r_rwds_s1, r_rwds_s2;

  logic [15:0]       r_cnt;
  logic              r_odd;
  logic [39:0]       r_ca;
  logic              r_rw, r_as;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wbyte;
  logic [15:0]       r_cr0;
  logic              r_rd_pend, r_rd_hi;
  logic [7:0]        r_dq_out;
  logic              r_dq_oe, r_rwds_out, r_rwds_oe;

  logic [15:0]       r_mem [0:(1 << ADDR_W) - 1];
  logic [15:0]       r_mem_q;

  logic              w_edge, w_cs_fall, w_cs_rise, w_abort, w_data_edge;
  logic [47:0]       w_ca;
  logic [31:0]       w_addr_full;
  logic              w_wr_mem, w_we_hi, w_we_lo;
  logic [15:0]       w_rword;
  logic              w_unused;

  assign w_edge      = r_ck_s2 ^ r_ck_d;
  assign w_cs_fall   = r_cs_d & ~r_cs_s2;
  assign w_cs_rise   = ~r_cs_d & r_cs_s2;
  assign w_abort     = w_cs_rise | ~r_rst_s2;
  assign w_ca        = {r_ca, r_dq_s2};
  assign w_addr_full = {w_ca[44:16], w_ca[2:0]};
  assign w_unused    = ^{w_ca[45], w_ca[15:3], w_addr_full[31:ADDR_W]};

  assign w_wr_mem = w_data_edge & ~r_rw & ~r_as;
  assign w_we_hi  = w_wr_mem & ~r_rwds_s2 & ~r_odd;
  assign w_we_lo  = w_wr_mem & ~r_rwds_s2 & r_odd;
  assign w_rword  = r_as ? (r_addr[0] ? r_cr0 : ID0) : r_mem_q;

  assign dq_out   = r_dq_out;
  assign dq_oe    = r_dq_oe;
  assign rwds_out = r_rwds_out;
  assign rwds_oe  = r_rwds_oe;
  assign busy     = (r_state != S_IDLE);

  // DQ/RWDS ride through the same two stages as CK so each byte lines up with its edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ck_s1   <= 1'b0;
      r_ck_s2   <= 1'b0;
      r_ck_d    <= 1'b0;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_d    <= 1'b1;
      r_rst_s1  <= 1'b1;
      r_rst_s2  <= 1'b1;
      r_dq_s1   <= '0;
      r_dq_s2   <= '0;
      r_rwds_s1 <= 1'b0;
      r_rwds_s2 <= 1'b0;
    end else begin
      r_ck_s1   <= hb_ck;
      r_ck_s2   <= r_ck_s1;
      r_ck_d    <= r_ck_s2;
      r_cs_s1   <= hb_cs_l;
      r_cs_s2   <= r_cs_s1;
      r_cs_d    <= r_cs_s2;
      r_rst_s1  <= hb_rst_l;
      r_rst_s2  <= r_rst_s1;
      r_dq_s1   <= dq_in;
      r_dq_s2   <= r_dq_s1;
      r_rwds_s1 <= rwds_in;
      r_rwds_s2 <= r_rwds_s1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_edge = 1'b0;
    case (r_state)
      S_IDLE:  if (w_cs_fall) w_state_nxt = S_CA;
      S_CA:    if (w_edge && r_cnt == 16'd5)
                 w_state_nxt = (!w_ca[47] && w_ca[46]) ? S_WDATA : S_LAT;
      S_LAT:   if (w_edge && r_cnt == D0) begin
                 w_data_edge = 1'b1;
                 w_state_nxt = r_rw ? S_RDATA : S_WDATA;
               end
      S_RDATA: w_data_edge = w_edge;
      S_WDATA: begin
                 w_data_edge = w_edge;
                 if (w_edge && r_as && r_odd) w_state_nxt = S_IDLE;
               end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_data_edge = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt      <= '0;
      r_odd      <= 1'b0;
      r_ca       <= '0;
      r_rw       <= 1'b0;
      r_as       <= 1'b0;
      r_addr     <= '0;
      r_wbyte    <= '0;
      r_cr0      <= CR0_RST;
      r_rd_pend  <= 1'b0;
      r_rd_hi    <= 1'b0;
      r_dq_out   <= '0;
      r_dq_oe    <= 1'b0;
      r_rwds_out <= 1'b0;
      r_rwds_oe  <= 1'b0;
    end else if (w_abort) begin
      r_rd_pend  <= 1'b0;
      r_dq_oe    <= 1'b0;
      r_rwds_oe  <= 1'b0;
      r_rwds_out <= 1'b0;
      if (!r_rst_s2) r_cr0 <= CR0_RST;
    end else begin
      r_rd_pend <= 1'b0;
      if (r_rd_pend) begin
        r_dq_out   <= r_rd_hi ? w_rword[15:8] : w_rword[7:0];
        r_rwds_out <= r_rd_hi;
      end
      case (r_state)
        S_IDLE: if (w_cs_fall) begin
          r_cnt <= '0;
          r_odd <= 1'b0;
        end
        S_CA: if (w_edge) begin
          r_ca       <= {r_ca[31:0], r_dq_s2};
          r_cnt      <= r_cnt + 16'd1;
          r_rwds_oe  <= 1'b1;
          r_rwds_out <= DOUBLE_LAT;
          if (r_cnt == 16'd5) begin
            r_rw   <= w_ca[47];
            r_as   <= w_ca[46];
            r_addr <= w_addr_full[ADDR_W-1:0];
          end
        end
        S_LAT: if (w_edge) r_cnt <= r_cnt + 16'd1;
        default: ;
      endcase
      // Register space never advances the address, so a register read repeats one word.
      if (w_data_edge) begin
        r_odd <= ~r_odd;
        if (r_rw) begin
          r_rd_pend <= 1'b1;
          r_rd_hi   <= ~r_odd;
          r_dq_oe   <= 1'b1;
          if (r_odd && !r_as) r_addr <= r_addr + 1'b1;
        end else begin
          r_rwds_oe <= 1'b0;
          if (r_as) begin
            if (!r_odd) r_wbyte <= r_dq_s2;
            else        r_cr0   <= {r_wbyte, r_dq_s2};
          end else if (r_odd) begin
            r_addr <= r_addr + 1'b1;
          end
        end
      end
    end
  end

  // The read word is refetched every cycle from the pre-increment address, so the low
  // byte driven one cycle after an odd edge still comes from the word just finished.
  always_ff @(posedge clk) begin
    if (w_we_hi) r_mem[r_addr][15:8] <= r_dq_s2;
    if (w_we_lo) r_mem[r_addr][7:0]  <= r_dq_s2;
    r_mem_q <= r_mem[r_addr];
  end

endmodule
